// File: rtl/pixel_array_ctrl_if.sv
// Purpose: bundles the pixel-array control, shared DATA bus and pixel output signals.
// Ports: master = sequencing controller side, slave = array / downstream side.
// Widths follow CNT_W (DATA bus width) and NPIX (one READ line per pixel).
interface pixel_array_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int NPIX  = 4
);
    logic             START;
    logic             CONTINUOUS;
    logic [7:0]       EXPOSE_TIME;
    logic             ERASE;
    logic             ARRAY_RESET;
    logic             EXPOSE;
    logic             CONVERT;
    logic [NPIX-1:0]  READ;
    logic [CNT_W-1:0] DATA_OUT;
    logic             DATA_OUT_EN;
    logic [CNT_W-1:0] DATA_IN;
    logic [CNT_W-1:0] PIXEL_DATA;
    logic [1:0]       PIXEL_IDX;
    logic             PIXEL_VALID;
    logic             BUSY;
    logic             FRAME_DONE;

    modport master (
        input  START, CONTINUOUS, EXPOSE_TIME, DATA_IN,
        output ERASE, ARRAY_RESET, EXPOSE, CONVERT, READ, DATA_OUT, DATA_OUT_EN,
               PIXEL_DATA, PIXEL_IDX, PIXEL_VALID, BUSY, FRAME_DONE
    );

    modport slave (
        output START, CONTINUOUS, EXPOSE_TIME, DATA_IN,
        input  ERASE, ARRAY_RESET, EXPOSE, CONVERT, READ, DATA_OUT, DATA_OUT_EN,
               PIXEL_DATA, PIXEL_IDX, PIXEL_VALID, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/pixel_array_ctrl.sv
// Purpose: frame sequencer for the 2x2 pixel array: erase, expose, ramp conversion,
//          bus turnaround, then one two-cycle read slot per pixel.
// Ports: clk, reset (async, active-high); bus = pixel_array_ctrl_if.master.
// Latency: START sampled at edge k -> ERASE high from cycle k+1; pixel strobe one cycle
//          after its sample. No backpressure: START is ignored while BUSY, no queuing.
module pixel_array_ctrl #(
    parameter int ERASE_CYCLES = 5,
    parameter int CNT_W        = 8,
    parameter int NPIX         = 4
) (
    input  logic               clk,
    input  logic               reset,
    pixel_array_ctrl_if.master bus
);
    // One shared counter serves every timed state, so it must hold the largest of:
    // conversion count, 8-bit exposure, erase length and read-slot count.
    localparam int CW_A = (CNT_W > 8) ? CNT_W : 8;
    localparam int CW_B = ($clog2(ERASE_CYCLES + 1) > CW_A) ? $clog2(ERASE_CYCLES + 1) : CW_A;
    localparam int CW   = ($clog2(2 * NPIX + 1) > CW_B) ? $clog2(2 * NPIX + 1) : CW_B;

    localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'({CNT_W{1'b1}});
    localparam logic [CW-1:0] READ_LAST  = CW'(2 * NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_READ,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [7:0]      exp_len, exp_len_nx;
    logic [7:0]      exp_lat;
    logic [CW-1:0]   expose_last;

    // Next values of the registered array-side outputs.
    logic             erase_nx, expose_nx, convert_nx, dout_en_nx, busy_nx, done_nx;
    logic [NPIX-1:0]  read_nx;
    logic [CNT_W-1:0] dout_nx;

    // Output registers.
    logic             erase_q, expose_q, convert_q, dout_en_q, busy_q, done_q;
    logic [NPIX-1:0]  read_q;
    logic [CNT_W-1:0] dout_q;
    logic [CNT_W-1:0] pix_dat_q;
    logic [1:0]       pix_idx_q;
    logic             pix_vld_q;
    logic             sample;

    // A zero exposure request still gives one exposure cycle.
    assign exp_lat     = (bus.EXPOSE_TIME == 8'd0) ? 8'd1 : bus.EXPOSE_TIME;
    assign expose_last = CW'(exp_len - 8'd1);

    // Second cycle of each read slot: bus has settled for a full cycle.
    assign sample = (state == S_READ) && cnt[0];

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        exp_len_nx = exp_len;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    state_nx   = S_ERASE;
                    cnt_nx     = '0;
                    exp_len_nx = exp_lat;
                end
            end
            S_ERASE: begin
                if (cnt == ERASE_LAST) begin
                    state_nx = S_EXPOSE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_EXPOSE: begin
                if (cnt == expose_last) begin
                    state_nx = S_CONVERT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_CONVERT: begin
                if (cnt == CONV_LAST) begin
                    state_nx = S_TURN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_TURN: begin
                state_nx = S_READ;
                cnt_nx   = '0;
            end
            S_READ: begin
                if (cnt == READ_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: begin
                cnt_nx = '0;
                if (bus.CONTINUOUS) begin
                    state_nx   = S_ERASE;
                    exp_len_nx = exp_lat;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so every
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        erase_nx   = (state_nx == S_ERASE);
        expose_nx  = (state_nx == S_EXPOSE);
        convert_nx = (state_nx == S_CONVERT);
        dout_en_nx = (state_nx == S_CONVERT);
        busy_nx    = (state_nx != S_IDLE);
        done_nx    = (state_nx == S_DONE);
        dout_nx    = '0;
        read_nx    = '0;
        if (state_nx == S_CONVERT) begin
            dout_nx = cnt_nx[CNT_W-1:0];
        end
        if (state_nx == S_READ) begin
            // Two counter steps per pixel: cnt[CW-1:1] is the pixel index.
            read_nx = {{(NPIX-1){1'b0}}, 1'b1} << cnt_nx[CW-1:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            exp_len   <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            dout_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_q    <= '0;
            dout_q    <= '0;
            pix_dat_q <= '0;
            pix_idx_q <= '0;
            pix_vld_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            exp_len   <= exp_len_nx;
            erase_q   <= erase_nx;
            expose_q  <= expose_nx;
            convert_q <= convert_nx;
            dout_en_q <= dout_en_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            read_q    <= read_nx;
            dout_q    <= dout_nx;
            pix_vld_q <= sample;
            if (sample) begin
                pix_dat_q <= bus.DATA_IN;
                pix_idx_q <= cnt[2:1];
            end
        end
    end

    assign bus.ERASE       = erase_q;
    assign bus.ARRAY_RESET = erase_q;
    assign bus.EXPOSE      = expose_q;
    assign bus.CONVERT     = convert_q;
    assign bus.READ        = read_q;
    assign bus.DATA_OUT    = dout_q;
    assign bus.DATA_OUT_EN = dout_en_q;
    assign bus.PIXEL_DATA  = pix_dat_q;
    assign bus.PIXEL_IDX   = pix_idx_q;
    assign bus.PIXEL_VALID = pix_vld_q;
    assign bus.BUSY        = busy_q;
    assign bus.FRAME_DONE  = done_q;
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Purpose: directed bench for pixel_array_ctrl; acts as the array (drives DATA_IN on READ).
// Ports: none; instantiates pixel_array_ctrl_if and the controller with default params.
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
module tb_pixel_array_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pixel_array_ctrl_if #(.CNT_W(8), .NPIX(4)) pif ();

    pixel_array_ctrl #(
        .ERASE_CYCLES(5),
        .CNT_W       (8),
        .NPIX        (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (pif)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pix_val [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // [29]ERASE [28]ARRAY_RESET [27]EXPOSE [26]CONVERT [25:22]READ [21:14]DATA_OUT
    // [13]DATA_OUT_EN [12:5]PIXEL_DATA [4:3]PIXEL_IDX [2]PIXEL_VALID [1]BUSY [0]FRAME_DONE
    function automatic logic [31:0] pack_out();
        logic [31:0] v;
        v = {2'b00, pif.ERASE, pif.ARRAY_RESET, pif.EXPOSE, pif.CONVERT, pif.READ,
             pif.DATA_OUT, pif.DATA_OUT_EN, pif.PIXEL_DATA, pif.PIXEL_IDX,
             pif.PIXEL_VALID, pif.BUSY, pif.FRAME_DONE};
        return v;
    endfunction

    // Expected outputs on frame cycle t (t=0 is the first ERASE cycle) for exposure e.
    function automatic logic [31:0] expect_vec(input int t, input int e);
        int c1;
        int c2;
        int r0;
        int dn;
        int k;
        logic [31:0] v;
        c1 = 5 + e;
        c2 = c1 + 256;
        r0 = c2 + 1;
        dn = r0 + 8;
        v  = '0;
        if (t < 5) begin
            v[29] = 1'b1;
            v[28] = 1'b1;
        end
        if (t >= 5 && t < c1) v[27] = 1'b1;
        if (t >= c1 && t < c2) begin
            v[26]    = 1'b1;
            v[21:14] = 8'(t - c1);
            v[13]    = 1'b1;
        end
        if (t >= r0 && t < dn) v[22 + (t - r0) / 2] = 1'b1;
        if (t > r0 && t <= dn && ((t - r0) % 2 == 0)) begin
            k       = (t - r0) / 2 - 1;
            v[12:5] = pix_val[k];
            v[4:3]  = 2'(k);
            v[2]    = 1'b1;
        end
        v[1] = 1'b1;
        if (t == dn) v[0] = 1'b1;
        return v;
    endfunction

    // Runs one whole frame cycle by cycle. Pixel data/index are compared only while
    // PIXEL_VALID is expected. poke_t rewrites EXPOSE_TIME, start_t pulses START.
    task automatic run_frame(input string name, input int e, input logic cont,
                             input int poke_t, input logic [7:0] poke_val, input int start_t,
                             output int n_er, output int n_ex, output int n_cv,
                             output int n_vld, output int done_t, output logic [31:0] vsum);
        logic [31:0] got;
        logic [31:0] exp;
        int          len;
        len    = 271 + e;
        n_er   = 0;
        n_ex   = 0;
        n_cv   = 0;
        n_vld  = 0;
        done_t = -1;
        vsum   = '0;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            got = pack_out();
            exp = expect_vec(t, e);
            if (!got[2]) got[12:3] = '0;
            if (!exp[2]) exp[12:3] = '0;
            check($sformatf("%s_t%0d", name, t), got, exp);
            if (pif.ERASE) n_er++;
            if (pif.EXPOSE) n_ex++;
            if (pif.CONVERT) n_cv++;
            if (pif.PIXEL_VALID) begin
                n_vld++;
                vsum = {vsum[23:0], pif.PIXEL_DATA};
            end
            if (pif.FRAME_DONE) done_t = t;
            pif.START = (t == start_t);
            if (t == 0) pif.CONTINUOUS = cont;
            if (t == poke_t) pif.EXPOSE_TIME = poke_val;
            pif.DATA_IN = 8'hEE;
            for (int i = 0; i < 4; i++) begin
                if (pif.READ[i]) pif.DATA_IN = pix_val[i];
            end
        end
    endtask

    always @(negedge clk) begin
        check("inv_bus_contention", 32'(pif.DATA_OUT_EN & (|pif.READ)), 32'd0);
        check("inv_read_onehot0", 32'($onehot0(pif.READ)), 32'd1);
        check("inv_erase_expose", 32'(pif.ERASE & pif.EXPOSE), 32'd0);
    end

    initial begin
        int          n_er;
        int          n_ex;
        int          n_cv;
        int          n_vld;
        int          done_t;
        logic [31:0] vsum;

        pif.START       = 1'b0;
        pif.CONTINUOUS  = 1'b0;
        pif.EXPOSE_TIME = 8'd0;
        pif.DATA_IN     = 8'd0;

        repeat (2) @(negedge clk);
        check("reset_outputs", pack_out(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", pack_out(), 32'd0);

        // Frame 1: EXPOSE_TIME=10, single START pulse.
        pix_val = '{8'h11, 8'h22, 8'h33, 8'h44};
        pif.START       = 1'b1;
        pif.EXPOSE_TIME = 8'd10;
        run_frame("f1", 10, 1'b0, -1, 8'd0, -1, n_er, n_ex, n_cv, n_vld, done_t, vsum);
        check("f1_erase_cycles", 32'(n_er), 32'd5);
        check("f1_expose_cycles", 32'(n_ex), 32'd10);
        check("f1_convert_cycles", 32'(n_cv), 32'd256);
        check("f1_valid_count", 32'(n_vld), 32'd4);
        check("f1_done_cycle", 32'(done_t), 32'd280);
        check("f1_pixels", vsum, 32'h11223344);
        @(negedge clk);
        check("f1_idle_busy", 32'(pif.BUSY), 32'd0);

        // Frame 2: EXPOSE_TIME=0 acts as 1; raising it to 200 mid-exposure has no effect.
        pix_val = '{8'h80, 8'h01, 8'hFE, 8'h7F};
        pif.START       = 1'b1;
        pif.EXPOSE_TIME = 8'd0;
        run_frame("f2", 1, 1'b0, 5, 8'd200, -1, n_er, n_ex, n_cv, n_vld, done_t, vsum);
        check("f2_expose_cycles", 32'(n_ex), 32'd1);
        check("f2_done_cycle", 32'(done_t), 32'd271);
        check("f2_pixels", vsum, 32'h8001FE7F);
        @(negedge clk);
        check("f2_idle_busy", 32'(pif.BUSY), 32'd0);

        // Continuous pair: exposures 3 then 7, START pulses while busy ignored.
        pix_val = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        pif.START       = 1'b1;
        pif.EXPOSE_TIME = 8'd3;
        pif.CONTINUOUS  = 1'b1;
        run_frame("c1", 3, 1'b1, 20, 8'd7, 100, n_er, n_ex, n_cv, n_vld, done_t, vsum);
        check("c1_expose_cycles", 32'(n_ex), 32'd3);
        check("c1_done_cycle", 32'(done_t), 32'd273);
        check("c1_pixels", vsum, 32'hA1B2C3D4);
        run_frame("c2", 7, 1'b0, -1, 8'd0, 50, n_er, n_ex, n_cv, n_vld, done_t, vsum);
        check("c2_erase_cycles", 32'(n_er), 32'd5);
        check("c2_expose_cycles", 32'(n_ex), 32'd7);
        check("c2_done_cycle", 32'(done_t), 32'd277);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("c2_no_queued_start_%0d", i), 32'(pif.BUSY), 32'd0);
        end

        // Reset in the middle of conversion.
        pif.START       = 1'b1;
        pif.EXPOSE_TIME = 8'd10;
        for (int t = 0; t <= 143; t++) begin
            @(negedge clk);
            pif.START = 1'b0;
        end
        check("rst_pre_dout", 32'(pif.DATA_OUT), 32'h80);
        check("rst_pre_convert", 32'(pif.CONVERT & pif.DATA_OUT_EN), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_outputs", pack_out(), 32'd0);
        @(negedge clk);
        check("rst_held_outputs", pack_out(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_idle_%0d", i), pack_out(), 32'd0);
        end

        // Recovery frame after the aborted one.
        pix_val = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
        pif.START       = 1'b1;
        pif.EXPOSE_TIME = 8'd2;
        run_frame("f3", 2, 1'b0, -1, 8'd0, -1, n_er, n_ex, n_cv, n_vld, done_t, vsum);
        check("f3_done_cycle", 32'(done_t), 32'd272);
        check("f3_pixels", vsum, 32'h5AA500FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
Sequencing controller for the 2 x 2 pixel array. It runs one frame per request: erase, expose, ramp conversion, turnaround, then four sequential pixel reads. During conversion it drives an 8-bit Gray-free binary count onto the shared DATA bus. During readout it captures each pixel's 8-bit value from the bus and presents it to downstream logic with a valid strobe.

Parameters:
ERASE_CYCLES, 5, cycles ERASE and ARRAY_RESET are held high (min 1)
CNT_W, 8, conversion counter width; equals DATA bus width
NPIX, 4, number of pixels read per frame; one READ line each

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
START  input  1  frame request; sampled in IDLE only
CONTINUOUS  input  1  when high at end of frame, next frame starts without START
EXPOSE_TIME  input  8  exposure length in cycles; latched on frame start; 0 treated as 1
ERASE  output  1  to array ERASE
ARRAY_RESET  output  1  to array RESET
EXPOSE  output  1  to array EXPOSE
CONVERT  output  1  enables external RAMP generator
READ  output  NPIX  one-hot pixel read selects (READ[0] = READ1)
DATA_OUT  output  CNT_W  conversion count driven to DATA bus
DATA_OUT_EN  output  1  tri-state enable for DATA_OUT onto DATA bus
DATA_IN  input  CNT_W  DATA bus sampled during readout
PIXEL_DATA  output  CNT_W  captured pixel value
PIXEL_IDX  output  2  index of pixel in PIXEL_DATA
PIXEL_VALID  output  1  one-cycle strobe; PIXEL_DATA/IDX valid
BUSY  output  1  high in every state except IDLE
FRAME_DONE  output  1  one-cycle pulse on last frame cycle

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, DATA_OUT=0, exposure latch=0, counters=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> TURN -> READ -> DONE -> IDLE/ERASE.
- IDLE: START=1 at edge k latches EXPOSE_TIME (0 -> 1) and enters ERASE. ERASE is high from cycle k+1.
- ERASE: ERASE=ARRAY_RESET=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly the latched number of cycles. ERASE and EXPOSE are never high together.
- CONVERT: CONVERT=1, DATA_OUT_EN=1 for 2^CNT_W cycles.
  - DATA_OUT = 0 on the first cycle and increments by 1 each cycle to 2^CNT_W-1.
  - There is no wrap inside the state; the state exits after the all-ones cycle.
- TURN: exactly 1 cycle with DATA_OUT_EN=0, all READ=0. This guarantees no bus contention. DATA_OUT returns to 0.
- READ: 2 cycles per pixel, in order i = 0..NPIX-1.
  - Slot cycle 0: READ[i]=1 (bus settle).
  - Slot cycle 1: READ[i]=1, DATA_IN is sampled into PIXEL_DATA, and PIXEL_IDX=i.
  - PIXEL_VALID=1 on the cycle after the sample (registered) for exactly one cycle.
  - READ is one-hot or zero at all times. DATA_OUT_EN=0 throughout READ.
- DONE: 1 cycle with FRAME_DONE=1, BUSY=1. This cycle also carries PIXEL_VALID for the last pixel.
  - Next state is ERASE if CONTINUOUS=1, else IDLE.
  - CONTINUOUS re-latches EXPOSE_TIME on the DONE cycle.
- START is ignored while BUSY, with no queuing. START held high in IDLE starts one frame; another starts only if it is still high on return to IDLE.
- EXPOSE_TIME changes mid-frame have no effect on the current frame.
- Frame length from the first ERASE cycle to DONE inclusive: ERASE_CYCLES + E + 2^CNT_W + 1 + 2*NPIX + 1. With defaults and E=10 this is 281 cycles.
- Reset mid-frame: all outputs drop asynchronously to 0, DATA_OUT_EN=0 immediately, and the state returns to IDLE. No PIXEL_VALID or FRAME_DONE is produced for the partial frame.

Test Plan:
- Reset, then START pulse with EXPOSE_TIME=10 -> ERASE high 5 cycles, EXPOSE high 10, CONVERT/DATA_OUT_EN high 256 with DATA_OUT 0..255, 1 idle TURN cycle, READ = 0001,0001,0010,0010,0100,0100,1000,1000, FRAME_DONE at cycle 281 after ERASE start.
- Bench drives DATA_IN = 0x11,0x22,0x33,0x44 during READ1..READ4 -> four PIXEL_VALID strobes with PIXEL_IDX 0..3 and PIXEL_DATA 0x11,0x22,0x33,0x44; the last strobe coincides with FRAME_DONE.
- EXPOSE_TIME=0 -> EXPOSE high exactly 1 cycle. Changing EXPOSE_TIME to 200 mid-EXPOSE does not extend the exposure.
- CONTINUOUS=1 over two frames with EXPOSE_TIME 3 then 7 -> ERASE follows DONE directly with no IDLE cycle; exposures are 3 and 7 cycles; START pulses during BUSY are ignored.
- Assert reset during CONVERT at DATA_OUT=0x80 -> same-cycle DATA_OUT_EN=0, CONVERT=0, all outputs 0; after release, BUSY=0 until START.
- Assertion checks throughout: DATA_OUT_EN and any READ never high together; READ $onehot0; ERASE&EXPOSE never high.
